multi_interval_timer: RTL

Parametrised multi-channel interval timer, an Avalon-MM slave on the Nios system bus. Each of NCH channels has its own period, prescaler, one-shot/continuous mode, timeout status, snapshot and interrupt. It replaces single-channel 16-bit-bus timers where software needs several independent time bases and full-width 32-bit register access.

---
 rtl/multi_interval_timer_pkg.sv | 28 ++
 rtl/multi_interval_timer_if.sv | 16 +
 rtl/multi_interval_timer_channel.sv | 157 +++++++++++++++
 rtl/multi_interval_timer.sv | 85 ++++++++
 4 files changed

// File: rtl/multi_interval_timer_pkg.sv
// Shared register map, bit indices and bus payload type for multi_interval_timer.
package multi_interval_timer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 3;

  localparam logic [OFF_W-1:0] OFF_STATUS   = 3'd0;
  localparam logic [OFF_W-1:0] OFF_CONTROL  = 3'd1;
  localparam logic [OFF_W-1:0] OFF_PERIOD   = 3'd2;
  localparam logic [OFF_W-1:0] OFF_SNAP     = 3'd3;
  localparam logic [OFF_W-1:0] OFF_COMPARE  = 3'd4;
  localparam logic [OFF_W-1:0] OFF_PRESCALE = 3'd5;

  localparam int unsigned CTL_ITO   = 0;
  localparam int unsigned CTL_CONT  = 1;
  localparam int unsigned CTL_START = 2;
  localparam int unsigned CTL_STOP  = 3;

  localparam int unsigned ST_TO  = 0;
  localparam int unsigned ST_RUN = 1;

  // Register offset and write data as seen by one channel.
  typedef struct packed {
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] data;
  } bus_req_t;

endpackage

// File: rtl/multi_interval_timer_if.sv
// Avalon-MM slave bus bundle for multi_interval_timer.
interface multi_interval_timer_if #(
  parameter int unsigned NCH = 4
);
  localparam int unsigned AW = $clog2(NCH) + 3;

  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic          read_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  modport master (output address, chipselect, write_n, read_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, read_n, writedata, output readdata);
endinterface

// File: rtl/multi_interval_timer_channel.sv
// One timer channel: prescaler, down counter, RUN/TO, registers and local read mux.
// Compare/PWM logic is built only with MULTI_INTERVAL_TIMER_PWM_EN defined.
module timer_channel
  import multi_interval_timer_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned PRE_W      = 8,
  parameter int unsigned PERIOD_RST = 49999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  bus_req_t          wr_req,
  output logic [DATA_W-1:0] rdata_c,
  output logic              irq,
  output logic              irq_nxt_c
`ifdef MULTI_INTERVAL_TIMER_PWM_EN
  ,
  output logic              pwm
`endif
);

  logic [PRE_W-1:0] pre_q, pre_d, prescale_q, prescale_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, snap_q, snap_d;
  logic             ito_q, ito_d, cont_q, cont_d, run_q, run_d, to_q, to_d, irq_q, irq_d;
  logic             tick_c, zero_tick_c;
  logic             unused_data;

`ifdef MULTI_INTERVAL_TIMER_PWM_EN
  logic [CNT_W-1:0] compare_q, compare_d;
  logic             pwm_q, pwm_d;
`endif

  assign unused_data = ^wr_req.data;

  // Counting first, then bus writes override; the order encodes the collision rules.
  always_comb begin
    pre_d      = pre_q;
    prescale_d = prescale_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    snap_d     = snap_q;
    ito_d      = ito_q;
    cont_d     = cont_q;
    run_d      = run_q;
    to_d       = to_q;
`ifdef MULTI_INTERVAL_TIMER_PWM_EN
    compare_d  = compare_q;
    pwm_d      = run_q & (cnt_q < compare_q);
`endif

    tick_c      = run_q && (pre_q == prescale_q);
    zero_tick_c = tick_c && (cnt_q == '0);

    if (run_q) pre_d = tick_c ? '0 : pre_q + PRE_W'(1);

    if (tick_c) begin
      if (zero_tick_c) begin
        cnt_d = period_q;
        to_d  = 1'b1;
        if (!cont_q) run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    if (wr_en) begin
      case (wr_req.off)
        OFF_STATUS:  to_d = zero_tick_c;
        OFF_CONTROL: begin
          ito_d  = wr_req.data[CTL_ITO];
          cont_d = wr_req.data[CTL_CONT];
          if (wr_req.data[CTL_START]) run_d = 1'b1;
          if (wr_req.data[CTL_STOP])  run_d = 1'b0;
        end
        OFF_PERIOD: begin
          period_d = wr_req.data[CNT_W-1:0];
          cnt_d    = wr_req.data[CNT_W-1:0];
          pre_d    = '0;
          run_d    = 1'b0;
          to_d     = to_q;
        end
        OFF_SNAP:     snap_d     = cnt_q;
`ifdef MULTI_INTERVAL_TIMER_PWM_EN
        OFF_COMPARE:  compare_d  = wr_req.data[CNT_W-1:0];
`endif
        OFF_PRESCALE: prescale_d = wr_req.data[PRE_W-1:0];
        default: ;
      endcase
    end

    irq_d = to_d & ito_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q      <= '0;
      prescale_q <= '0;
      cnt_q      <= CNT_W'(PERIOD_RST);
      period_q   <= CNT_W'(PERIOD_RST);
      snap_q     <= '0;
      ito_q      <= 1'b0;
      cont_q     <= 1'b0;
      run_q      <= 1'b0;
      to_q       <= 1'b0;
      irq_q      <= 1'b0;
`ifdef MULTI_INTERVAL_TIMER_PWM_EN
      compare_q  <= '0;
      pwm_q      <= 1'b0;
`endif
    end else begin
      pre_q      <= pre_d;
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      snap_q     <= snap_d;
      ito_q      <= ito_d;
      cont_q     <= cont_d;
      run_q      <= run_d;
      to_q       <= to_d;
      irq_q      <= irq_d;
`ifdef MULTI_INTERVAL_TIMER_PWM_EN
      compare_q  <= compare_d;
      pwm_q      <= pwm_d;
`endif
    end
  end

  // Per-channel read mux; unused fields read as zero.
  always_comb begin
    rdata_c = '0;
    case (wr_req.off)
      OFF_STATUS: begin
        rdata_c[ST_TO]  = to_q;
        rdata_c[ST_RUN] = run_q;
      end
      OFF_CONTROL: begin
        rdata_c[CTL_ITO]  = ito_q;
        rdata_c[CTL_CONT] = cont_q;
      end
      OFF_PERIOD:   rdata_c = DATA_W'(period_q);
      OFF_SNAP:     rdata_c = DATA_W'(snap_q);
`ifdef MULTI_INTERVAL_TIMER_PWM_EN
      OFF_COMPARE:  rdata_c = DATA_W'(compare_q);
`endif
      OFF_PRESCALE: rdata_c = DATA_W'(prescale_q);
      default: ;
    endcase
  end

  assign irq       = irq_q;
  assign irq_nxt_c = irq_d;
`ifdef MULTI_INTERVAL_TIMER_PWM_EN
  assign pwm       = pwm_q;
`endif

endmodule

// File: rtl/multi_interval_timer.sv
// Multi-channel interval timer, Avalon-MM slave: channel decode, read register, irq OR.
// Optional compare/PWM outputs are built with MULTI_INTERVAL_TIMER_PWM_EN defined.
module multi_interval_timer
  import multi_interval_timer_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned PRE_W      = 8,
  parameter int unsigned PERIOD_RST = 49999
) (
  input  logic                  clk,
  input  logic                  reset,
  multi_interval_timer_if.slave bus,
  output logic [NCH-1:0]        irq,
  output logic                  irq_any
`ifdef MULTI_INTERVAL_TIMER_PWM_EN
  ,
  output logic [NCH-1:0]        pwm_out
`endif
);

  localparam int unsigned AW = $clog2(NCH) + 3;

  logic [AW-1:0]     addr_c;
  logic [31:0]       ch_num_c;
  logic              wr_c;
  bus_req_t          req_c;
  logic [DATA_W-1:0] ch_rdata [NCH];
  logic [NCH-1:0]    ch_irq, ch_irq_nxt;
  logic [DATA_W-1:0] rdata_sel_c;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              irq_any_q, irq_any_d;
  logic              unused_read_n;

  assign unused_read_n = bus.read_n;
  assign addr_c        = bus.address;
  assign ch_num_c      = 32'(addr_c >> 3);
  assign wr_c          = bus.chipselect && !bus.write_n && (ch_num_c < 32'(NCH));
  assign req_c         = '{off: addr_c[OFF_W-1:0], data: bus.writedata};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    timer_channel #(
      .CNT_W      (CNT_W),
      .PRE_W      (PRE_W),
      .PERIOD_RST (PERIOD_RST)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_c && (ch_num_c == 32'(g))),
      .wr_req    (req_c),
      .rdata_c   (ch_rdata[g]),
      .irq       (ch_irq[g]),
      .irq_nxt_c (ch_irq_nxt[g])
`ifdef MULTI_INTERVAL_TIMER_PWM_EN
      ,
      .pwm       (pwm_out[g])
`endif
    );
  end

  // Channel indices beyond NCH match nothing and read zero.
  always_comb begin
    rdata_sel_c = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (ch_num_c == 32'(i)) rdata_sel_c = ch_rdata[i];
    end
    readdata_d = bus.chipselect ? rdata_sel_c : readdata_q;
    irq_any_d  = |ch_irq_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= '0;
      irq_any_q  <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      irq_any_q  <= irq_any_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = ch_irq;
  assign irq_any      = irq_any_q;

endmodule
